mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto one line-wide data memory.
// Optional MEM_ARBITER_FIXED_PRIO_EN: dcache always wins ties.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   p0_* : icache request/response (enable held until ack)
//   p1_* : dcache request/response
//   mem_*_o / mem_*_i : data-memory request and response
//   grant_o : owning port while busy_o
//   busy_o  : a transaction is in flight
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_mem_enable_i,
  input  logic              p0_mem_write_i,
  input  logic [ADDR_W-1:0] p0_mem_addr_i,
  input  logic [DATA_W-1:0] p0_mem_data_i,
  output logic [DATA_W-1:0] p0_mem_data_o,
  output logic              p0_mem_ack_o,
  input  logic              p1_mem_enable_i,
  input  logic              p1_mem_write_i,
  input  logic [ADDR_W-1:0] p1_mem_addr_i,
  input  logic [DATA_W-1:0] p1_mem_data_i,
  output logic [DATA_W-1:0] p1_mem_data_o,
  output logic              p1_mem_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o,
  output logic              busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              win;
  logic              any_req;

  assign any_req = p0_mem_enable_i | p1_mem_enable_i;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win = p1_mem_enable_i;
  end
`else
  // Pointer names the port that wins the next tie.
  logic rr_q, rr_d;

  always_comb begin
    unique case ({p1_mem_enable_i, p0_mem_enable_i})
      2'b11:   win = rr_q;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) begin
      rr_d = ~win;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = win;
          write_d = win ? p1_mem_write_i : p0_mem_write_i;
          addr_d  = win ? p1_mem_addr_i  : p0_mem_addr_i;
          data_d  = win ? p1_mem_data_i  : p0_mem_data_i;
        end
      end
      BUSY: begin
        // Ack edge always lands in IDLE, so a still-high
        // enable cannot be re-granted in the same edge.
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy_o        = (state_q == BUSY);
  assign grant_o       = grant_q;
  assign mem_enable_o  = busy_o;
  assign mem_write_o   = write_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = data_q;
  assign p0_mem_data_o = mem_data_i;
  assign p1_mem_data_o = mem_data_i;
  assign p0_mem_ack_o  = busy_o & ~grant_q & mem_ack_i;
  assign p1_mem_ack_o  = busy_o &  grant_q & mem_ack_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Directed scenarios plus randomized traffic against a transaction model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_en = 0, p0_wr = 0, p1_en = 0, p1_wr = 0;
  logic [AW-1:0] p0_ad = '0, p1_ad = '0;
  logic [DW-1:0] p0_wd = '0, p1_wd = '0;
  logic [DW-1:0] p0_rd, p1_rd;
  logic          p0_ack, p1_ack;
  logic          m_en, m_wr;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rd = '0;
  logic          m_ack = 1'b0;
  logic          grant, busy;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .p0_mem_enable_i(p0_en), .p0_mem_write_i(p0_wr),
    .p0_mem_addr_i(p0_ad), .p0_mem_data_i(p0_wd),
    .p0_mem_data_o(p0_rd), .p0_mem_ack_o(p0_ack),
    .p1_mem_enable_i(p1_en), .p1_mem_write_i(p1_wr),
    .p1_mem_addr_i(p1_ad), .p1_mem_data_i(p1_wd),
    .p1_mem_data_o(p1_rd), .p1_mem_ack_o(p1_ack),
    .mem_enable_o(m_en), .mem_write_o(m_wr),
    .mem_addr_o(m_ad), .mem_data_o(m_wd),
    .mem_data_i(m_rd), .mem_ack_i(m_ack),
    .grant_o(grant), .busy_o(busy)
  );

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Tie winner from the arbitration rules, not from DUT state.
  function automatic int pick(input bit r0, input bit r1);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    return r1 ? 1 : 0;
`else
    if (r0 && r1) return m_ptr;
    return r1 ? 1 : 0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    p0_en = 0; p1_en = 0; m_ack = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({m_en, m_wr, grant, busy, p0_ack, p1_ack} !== 6'b0
        || m_ad !== '0 || m_wd !== '0) begin
      n_err++;
      $display("FAIL reset: en=%b wr=%b g=%b busy=%b ack=%b%b ad=%h",
               m_en, m_wr, grant, busy, p0_ack, p1_ack, m_ad);
    end
  endtask

  task automatic test_single_p1_read();
    logic [DW-1:0] rd;
    do_reset();
    p1_en = 1; p1_wr = 0; p1_ad = 32'h400;
    #1;
    n_cmp++;
    if (m_en !== 1'b0) begin
      n_err++; $display("FAIL p1rd_latency: en=%b want 0", m_en);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_en !== 1 || m_wr !== 0 || m_ad !== 32'h400
        || grant !== 1 || busy !== 1) begin
      n_err++;
      $display("FAIL p1rd_grant: en=%b wr=%b ad=%h g=%b want 1 0 400 1",
               m_en, m_wr, m_ad, grant);
    end
    repeat (10) @(negedge clk);
    rd = rnd_data();
    m_rd = rd; m_ack = 1;
    #1;
    n_cmp++;
    if (p1_ack !== 1 || p0_ack !== 0 || p1_rd !== rd || p0_rd !== rd) begin
      n_err++;
      $display("FAIL p1rd_ack: p1=%b p0=%b want 1 0 (data ok=%b)",
               p1_ack, p0_ack, p1_rd === rd);
    end
    @(posedge clk); #1;
    m_ack = 0; p1_en = 0;
    #1;
    n_cmp++;
    if (p1_ack !== 0 || busy !== 0 || m_en !== 0) begin
      n_err++;
      $display("FAIL p1rd_done: ack=%b busy=%b en=%b want 0 0 0",
               p1_ack, busy, m_en);
    end
  endtask

  task automatic test_contention();
    int w;
    do_reset();
    p0_en = 1; p1_en = 1; p0_ad = 32'h100; p1_ad = 32'h200;
    for (int k = 0; k < 4; k++) begin
      w = pick(1, 1);
      m_ptr = 1 - w;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1 || grant !== w[0]
          || m_ad !== (w == 1 ? 32'h200 : 32'h100)) begin
        n_err++;
        $display("FAIL contention_%0d: grant=%b ad=%h want %0d", k, grant, m_ad, w);
      end
      repeat (2) @(negedge clk);
      m_ack = 1;
      @(posedge clk); #1;
      m_ack = 0;
      n_cmp++;
      if (busy !== 0) begin
        n_err++; $display("FAIL contention_idle_%0d: busy=%b want 0", k, busy);
      end
    end
    p0_en = 0; p1_en = 0;
  endtask

  task automatic test_hold();
    logic [DW-1:0] orig;
    do_reset();
    orig = {8{32'hA5A5A5A5}};
    p1_en = 1; p1_wr = 1; p1_ad = 32'h20; p1_wd = orig;
    @(posedge clk); #1;
    p1_ad = 32'hDEAD_0000; p1_wd = rnd_data(); p1_wr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (m_en !== 1 || m_wr !== 1 || m_ad !== 32'h20 || m_wd !== orig) begin
        n_err++;
        $display("FAIL hold_%0d: en=%b wr=%b ad=%h want 1 1 20", k, m_en, m_wr, m_ad);
      end
    end
    m_ack = 1;
    @(posedge clk); #1;
    m_ack = 0; p1_en = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    p0_en = 1; p0_wr = 1; p0_ad = 32'h55; p0_wd = rnd_data();
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({m_en, m_wr, grant, busy} !== 4'b0 || m_ad !== '0 || m_wd !== '0) begin
      n_err++;
      $display("FAIL reset_mid: en=%b wr=%b g=%b busy=%b ad=%h want 0",
               m_en, m_wr, grant, busy, m_ad);
    end
    p0_en = 0;
    @(negedge clk);
    rst_n = 1;
    m_ptr = 0;
    @(negedge clk);
    m_ack = 1;
    #1;
    n_cmp++;
    if (p0_ack !== 0 || p1_ack !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL reset_mid_ack: p0=%b p1=%b busy=%b want 0 0 0",
               p0_ack, p1_ack, busy);
    end
    @(posedge clk); #1;
    m_ack = 0;
  endtask

  task automatic test_idle_ack();
    do_reset();
    m_ack = 1;
    #1;
    n_cmp++;
    if (p0_ack !== 0 || p1_ack !== 0) begin
      n_err++; $display("FAIL idle_ack: p0=%b p1=%b want 0 0", p0_ack, p1_ack);
    end
    @(posedge clk); #1;
    m_ack = 0;
    n_cmp++;
    if (busy !== 0 || m_en !== 0) begin
      n_err++; $display("FAIL idle_state: busy=%b en=%b want 0 0", busy, m_en);
    end
  endtask

  task automatic test_random();
    bit            pend[2];
    bit            wr[2];
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [DW-1:0] rd;
    int            w;
    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          pend[p] = 1;
          wr[p] = 1'($urandom_range(1, 0));
          ad[p] = $urandom;
          wd[p] = rnd_data();
        end
      end
      if (!pend[0] && !pend[1]) begin
        w = $urandom_range(1, 0);
        pend[w] = 1; wr[w] = 0; ad[w] = $urandom; wd[w] = rnd_data();
      end
      p0_en = pend[0]; p0_wr = wr[0]; p0_ad = ad[0]; p0_wd = wd[0];
      p1_en = pend[1]; p1_wr = wr[1]; p1_ad = ad[1]; p1_wd = wd[1];
      w = pick(pend[0], pend[1]);
      m_ptr = 1 - w;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1 || grant !== w[0] || m_ad !== ad[w]
          || m_wr !== wr[w] || m_wd !== wd[w]) begin
        n_err++;
        $display("FAIL rand_grant_%0d: g=%b ad=%h wr=%b want %0d %h %b",
                 it, grant, m_ad, m_wr, w, ad[w], wr[w]);
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
      @(negedge clk);
      rd = rnd_data();
      m_rd = rd; m_ack = 1;
      #1;
      n_cmp++;
      if ((w == 0 && (p0_ack !== 1 || p1_ack !== 0))
          || (w == 1 && (p1_ack !== 1 || p0_ack !== 0))
          || p0_rd !== rd || p1_rd !== rd) begin
        n_err++;
        $display("FAIL rand_ack_%0d: p0=%b p1=%b want port %0d", it, p0_ack, p1_ack, w);
      end
      @(posedge clk); #1;
      m_ack = 0;
      pend[w] = 0;
      if (w == 0) p0_en = 0; else p1_en = 0;
      n_cmp++;
      if (busy !== 0) begin
        n_err++; $display("FAIL rand_idle_%0d: busy=%b want 0", it, busy);
      end
    end
    @(negedge clk);
    p0_en = 0; p1_en = 0;
  endtask

  initial begin
    test_reset();
    test_single_p1_read();
    test_contention();
    test_hold();
    test_reset_mid();
    test_idle_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
